// File: rtl/video_timing_if.sv
// video_timing_if: groups the video timing generator's control inputs and timing outputs.
//  master: drives en_in and mode_in, and receives the timing outputs (renderer side).
//  slave:  receives en_in and mode_in, and drives the timing outputs (generator side).
interface video_timing_if #(
  parameter int HC_W = 11,
  parameter int VC_W = 10
);
  logic            en_in;
  logic            mode_in;
  logic            mode_out;
  logic [HC_W-1:0] hcount_out;
  logic [VC_W-1:0] vcount_out;
  logic            hs_out;
  logic            vs_out;
  logic            ad_out;
  logic            nf_out;
  logic [5:0]      fc_out;
  modport master (
    output en_in, mode_in,
    input  mode_out, hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out
  );
  modport slave (
    input  en_in, mode_in,
    output mode_out, hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out
  );
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: dual-mode (720p / 480p) video timing generator with pause and output pipeline.
//  clk_pixel_in  pixel clock
//  rst_in        asynchronous active-high reset
//  vt.en_in      1 = advance counters, 0 = freeze
//  vt.mode_in    requested mode (0 = 1280x720p60, 1 = 640x480p60), taken at frame wrap
//  vt.*_out      mode, h/v counters, hsync, vsync, active-draw, new-frame pulse and frame count,
//                all delayed by 1+OUT_LAT cycles and mutually aligned
module video_timing_gen #(
  parameter int HC_W    = 11,
  parameter int VC_W    = 10,
  parameter int FC_MAX  = 60,
  parameter int OUT_LAT = 0,
  parameter int H0_ACT  = 1280,
  parameter int H0_FP   = 110,
  parameter int H0_SYNC = 40,
  parameter int H0_BP   = 220,
  parameter int V0_ACT  = 720,
  parameter int V0_FP   = 5,
  parameter int V0_SYNC = 5,
  parameter int V0_BP   = 20,
  parameter int H1_ACT  = 640,
  parameter int H1_FP   = 16,
  parameter int H1_SYNC = 96,
  parameter int H1_BP   = 48,
  parameter int V1_ACT  = 480,
  parameter int V1_FP   = 10,
  parameter int V1_SYNC = 2,
  parameter int V1_BP   = 33
) (
  input logic          clk_pixel_in,
  input logic          rst_in,
  video_timing_if.slave vt
);
  localparam int OW = 1 + HC_W + VC_W + 4 + 6;
  // Reset image: mode 0 at (0,0) -> syncs inactive-low, inside active area
  localparam logic [OW-1:0] RST_VEC = {1'b0, {HC_W{1'b0}}, {VC_W{1'b0}}, 4'b0010, 6'd0};
  logic [HC_W-1:0] r_hc, w_h_act, w_hs_beg, w_hs_end, w_h_last;
  logic [VC_W-1:0] r_vc, w_v_act, w_vs_beg, w_vs_end, w_v_last;
  logic [5:0]      r_fc;
  logic            r_mode_cur, r_mode_req;
  logic            w_h_end, w_v_end, w_nf, w_hs, w_vs, w_ad;
  logic [OW-1:0]   w_dec;
  logic [OW-1:0]   r_pipe [OUT_LAT+1];
  assign w_h_act  = r_mode_cur ? HC_W'(H1_ACT) : HC_W'(H0_ACT);
  assign w_hs_beg = r_mode_cur ? HC_W'(H1_ACT + H1_FP) : HC_W'(H0_ACT + H0_FP);
  assign w_hs_end = r_mode_cur ? HC_W'(H1_ACT + H1_FP + H1_SYNC) : HC_W'(H0_ACT + H0_FP + H0_SYNC);
  assign w_h_last = r_mode_cur ? HC_W'(H1_ACT + H1_FP + H1_SYNC + H1_BP - 1)
                               : HC_W'(H0_ACT + H0_FP + H0_SYNC + H0_BP - 1);
  assign w_v_act  = r_mode_cur ? VC_W'(V1_ACT) : VC_W'(V0_ACT);
  assign w_vs_beg = r_mode_cur ? VC_W'(V1_ACT + V1_FP) : VC_W'(V0_ACT + V0_FP);
  assign w_vs_end = r_mode_cur ? VC_W'(V1_ACT + V1_FP + V1_SYNC) : VC_W'(V0_ACT + V0_FP + V0_SYNC);
  assign w_v_last = r_mode_cur ? VC_W'(V1_ACT + V1_FP + V1_SYNC + V1_BP - 1)
                               : VC_W'(V0_ACT + V0_FP + V0_SYNC + V0_BP - 1);
  assign w_h_end  = r_hc == w_h_last;
  assign w_v_end  = r_vc == w_v_last;
  assign w_nf     = vt.en_in && r_hc == w_h_act && r_vc == w_v_act;
  // Mode 1 syncs are active-low, so the raw sync window is inverted in that mode
  assign w_hs     = (r_hc >= w_hs_beg && r_hc < w_hs_end) ^ r_mode_cur;
  assign w_vs     = (r_vc >= w_vs_beg && r_vc < w_vs_end) ^ r_mode_cur;
  assign w_ad     = r_hc < w_h_act && r_vc < w_v_act;
  assign w_dec    = {r_mode_cur, r_hc, r_vc, w_hs, w_vs, w_ad, w_nf, r_fc};
  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      r_hc       <= '0;
      r_vc       <= '0;
      r_fc       <= '0;
      r_mode_cur <= 1'b0;
      r_mode_req <= 1'b0;
    end else begin
      r_mode_req <= vt.mode_in;
      if (vt.en_in) begin
        r_hc <= w_h_end ? '0 : r_hc + HC_W'(1);
        if (w_h_end) r_vc <= w_v_end ? '0 : r_vc + VC_W'(1);
        if (w_h_end && w_v_end) r_mode_cur <= r_mode_req;
        if (w_h_end && w_v_end && r_mode_req != r_mode_cur) r_fc <= '0;
        else if (w_nf) r_fc <= (r_fc == 6'(FC_MAX - 1)) ? '0 : r_fc + 6'd1;
      end
    end
  end
  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i <= OUT_LAT; i++) r_pipe[i] <= RST_VEC;
    end else begin
      r_pipe[0] <= w_dec;
      for (int i = 1; i <= OUT_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end
  assign {vt.mode_out, vt.hcount_out, vt.vcount_out, vt.hs_out, vt.vs_out,
          vt.ad_out, vt.nf_out, vt.fc_out} = r_pipe[OUT_LAT];
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench, full-size instance plus a shrunken-timing instance with OUT_LAT=2.
module tb_video_timing_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic mode = 1'b0;
  bit   in_rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  localparam logic [31:0] RV = {1'b0, 11'd0, 10'd0, 4'b0010, 6'd0};
  typedef struct { int h; int v; int fc; int mode; int req; } st_t;
  st_t st[2];
  int tab[2][2][8];
  int fcm[2];
  int lat[2];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  always #5 clk = ~clk;
  video_timing_if #(.HC_W(11), .VC_W(10)) vif0();
  video_timing_if #(.HC_W(11), .VC_W(10)) vif1();
  assign vif0.en_in = en;
  assign vif0.mode_in = mode;
  assign vif1.en_in = en;
  assign vif1.mode_in = mode;
  video_timing_gen #(.HC_W(11), .VC_W(10), .FC_MAX(60), .OUT_LAT(0)) dut0 (
    .clk_pixel_in(clk), .rst_in(rst), .vt(vif0));
  video_timing_gen #(.HC_W(11), .VC_W(10), .FC_MAX(4), .OUT_LAT(2),
    .H0_ACT(20), .H0_FP(3), .H0_SYNC(4), .H0_BP(5), .V0_ACT(6), .V0_FP(2), .V0_SYNC(2), .V0_BP(3),
    .H1_ACT(12), .H1_FP(2), .H1_SYNC(3), .H1_BP(2), .V1_ACT(5), .V1_FP(1), .V1_SYNC(2), .V1_BP(2)
  ) dut1 (.clk_pixel_in(clk), .rst_in(rst), .vt(vif1));
  function automatic logic [31:0] out_of(int k);
    return k == 0
      ? {vif0.mode_out, vif0.hcount_out, vif0.vcount_out, vif0.hs_out, vif0.vs_out, vif0.ad_out, vif0.nf_out, vif0.fc_out}
      : {vif1.mode_out, vif1.hcount_out, vif1.vcount_out, vif1.hs_out, vif1.vs_out, vif1.ad_out, vif1.nf_out, vif1.fc_out};
  endfunction
  // Expected outputs for the model's current position, straight from the mode tables
  function automatic logic [31:0] expect_out(int k, bit e);
    int t[8];
    bit hsa, vsa, hs, vs, ad, nf;
    logic [31:0] r;
    t = tab[k][st[k].mode];
    hsa = st[k].h >= t[0] + t[1] && st[k].h < t[0] + t[1] + t[2];
    vsa = st[k].v >= t[4] + t[5] && st[k].v < t[4] + t[5] + t[6];
    hs = (st[k].mode == 1) ? !hsa : hsa;
    vs = (st[k].mode == 1) ? !vsa : vsa;
    ad = st[k].h < t[0] && st[k].v < t[4];
    nf = e && st[k].h == t[0] && st[k].v == t[4];
    r = {st[k].mode == 1, 11'(st[k].h), 10'(st[k].v), hs, vs, ad, nf, 6'(st[k].fc)};
    return r;
  endfunction
  task automatic step(int k, bit e, bit mi);
    int t[8];
    int htot, vtot;
    t = tab[k][st[k].mode];
    htot = t[0] + t[1] + t[2] + t[3];
    vtot = t[4] + t[5] + t[6] + t[7];
    if (e) begin
      if (st[k].h == t[0] && st[k].v == t[4]) st[k].fc = (st[k].fc + 1) % fcm[k];
      if (st[k].h == htot - 1) begin
        st[k].h = 0;
        if (st[k].v == vtot - 1) begin
          st[k].v = 0;
          if (st[k].req != st[k].mode) begin
            st[k].mode = st[k].req;
            st[k].fc = 0;
          end
        end else st[k].v++;
      end else st[k].h++;
    end
    st[k].req = mi;
  endtask
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask
  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      st[k] = '{h: 0, v: 0, fc: 0, mode: 0, req: 0};
      for (int i = 0; i < lat[k]; i++) begin
        if (k == 0) q0.push_back(RV);
        else q1.push_back(RV);
      end
    end
  endtask
  // Called at a negedge: present inputs, record the expected response, advance the model
  task automatic drive_cycle(bit e, bit mi);
    en = e;
    mode = mi;
    q0.push_back(expect_out(0, e));
    q1.push_back(expect_out(1, e));
    step(0, e, mi);
    step(1, e, mi);
    @(negedge clk);
  endtask
  task automatic do_reset();
    #2;
    rst = 1'b1;
    in_rst = 1'b1;
    #1;
    chk("async_rst0", out_of(0), RV);
    chk("async_rst1", out_of(1), RV);
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
    in_rst = 1'b0;
  endtask
  always @(posedge clk) begin
    #1;
    if (!in_rst) begin
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out0 underflow t=%0t", $time);
      end else chk("out0", out_of(0), q0.pop_front());
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out1 underflow t=%0t", $time);
      end else chk("out1", out_of(1), q1.pop_front());
    end
  end
  initial begin
    int pause;
    bit m, mi, e;
    tab[0][0] = '{1280, 110, 40, 220, 720, 5, 5, 20};
    tab[0][1] = '{640, 16, 96, 48, 480, 10, 2, 33};
    tab[1][0] = '{20, 3, 4, 5, 6, 2, 2, 3};
    tab[1][1] = '{12, 2, 3, 2, 5, 1, 2, 2};
    fcm = '{60, 4};
    lat = '{0, 2};
    repeat (3) @(negedge clk);
    chk("reset0", out_of(0), RV);
    chk("reset1", out_of(1), RV);
    model_reset();
    rst = 1'b0;
    in_rst = 1'b0;
    for (int c = 0; c < 3400; c++) drive_cycle(1'b1, 1'b0);
    pause = 0;
    m = 1'b0;
    for (int c = 0; c < 30000; c++) begin
      if (c == 10000 || c == 20000 + int'($urandom_range(0, 500))) do_reset();
      if (pause == 0 && $urandom_range(0, 399) == 0) pause = int'($urandom_range(1, 40));
      if ($urandom_range(0, 699) == 0) m = !m;
      mi = m ^ ($urandom_range(0, 1999) == 0);
      e = (pause == 0) ? ($urandom_range(0, 19) != 0) : 1'b0;
      if (pause > 0) pause--;
      drive_cycle(e, mi);
    end
    in_rst = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
